alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU.
// Latency: grant + 2 cycles to rsp_valid. Backpressure: the response holds in RESP until rsp_ready; no grants outside IDLE.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_z,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             gnt_vld;
  logic             gnt_id;
  logic             op_id;
  logic [3:0]       op_ctl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  function automatic logic ctl_legal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1100, 4'b1101: ctl_legal = 1'b1;
      default:                   ctl_legal = 1'b0;
    endcase
  endfunction

  // Arbitration only happens in IDLE; prio breaks ties when both ports are valid.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = prio;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = gnt_vld && !gnt_id;
    req1_ready = gnt_vld && gnt_id;
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio   <= 1'b0;
      op_id  <= 1'b0;
      op_ctl <= '0;
      op_a   <= '0;
      op_b   <= '0;
    end else if (gnt_vld) begin
      prio   <= !gnt_id;
      op_id  <= gnt_id;
      op_ctl <= gnt_id ? req1_ctl : req0_ctl;
      op_a   <= gnt_id ? req1_a   : req0_a;
      op_b   <= gnt_id ? req1_b   : req0_b;
    end
  end

  assign alu_ctl = op_ctl;
  assign alu_a   = op_a;
  assign alu_b   = op_b;

  // Illegal codes still reach the ALU, but their result is squashed to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id  <= 1'b0;
      rsp_out <= '0;
      rsp_z   <= 1'b0;
      rsp_err <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id <= op_id;
      if (ctl_legal(op_ctl)) begin
        rsp_out <= alu_out;
        rsp_z   <= alu_z;
        rsp_err <= 1'b0;
      end else begin
        rsp_out <= '0;
        rsp_z   <= 1'b0;
        rsp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU and a response scoreboard.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [3:0] AND_C = 4'b0000, OR_C = 4'b0001, ADD_C = 4'b0010, SUB_C = 4'b0110;
  localparam logic [3:0] SLT_C = 4'b0111, NOR_C = 4'b1100, XOR_C = 4'b1101;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_ctl = '0, req1_ctl = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]   alu_ctl;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic         alu_z;
  logic         rsp_valid, rsp_id, rsp_z, rsp_err, busy;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_out;

  typedef struct packed {
    logic         id;
    logic [W-1:0] out;
    logic         z;
    logic         err;
  } rsp_t;

  rsp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic tb_prio = 1'b0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_z(rsp_z), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      AND_C:   alu_fn = a & b;
      OR_C:    alu_fn = a | b;
      ADD_C:   alu_fn = a + b;
      SUB_C:   alu_fn = a - b;
      SLT_C:   alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      NOR_C:   alu_fn = ~(a | b);
      XOR_C:   alu_fn = a ^ b;
      default: alu_fn = 32'hA5A5_0001;
    endcase
  endfunction

  function automatic logic is_legal(input logic [3:0] c);
    is_legal = (c == AND_C) || (c == OR_C) || (c == ADD_C) || (c == SUB_C) ||
               (c == SLT_C) || (c == NOR_C) || (c == XOR_C);
  endfunction

  assign alu_out = alu_fn(alu_ctl, alu_a, alu_b);
  assign alu_z   = (alu_out == '0);

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [3:0] c0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic [3:0] c1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    @(negedge clk);
    req0_valid = v0; req0_ctl = c0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_ctl = c1; req1_a = a1; req1_b = b1;
  endtask

  // Predicts the grant from the bench's own pointer and queues the expected response.
  task automatic grant_check(input string tag);
    logic         exp_vld, exp_id;
    logic [3:0]   c;
    logic [W-1:0] r;
    rsp_t         e;
    #1;
    exp_vld = req0_valid || req1_valid;
    exp_id  = (req0_valid && req1_valid) ? tb_prio : !req0_valid;
    check({tag, "_ready0"}, req0_ready, exp_vld && !exp_id);
    check({tag, "_ready1"}, req1_ready, exp_vld && exp_id);
    if (exp_vld) begin
      c = exp_id ? req1_ctl : req0_ctl;
      r = exp_id ? alu_fn(req1_ctl, req1_a, req1_b) : alu_fn(req0_ctl, req0_a, req0_b);
      e.id  = exp_id;
      e.err = !is_legal(c);
      e.out = e.err ? '0 : r;
      e.z   = e.err ? 1'b0 : (r == '0);
      sb.push_back(e);
      tb_prio = !exp_id;
    end
  endtask

  task automatic exec_check(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_exec_valid"}, rsp_valid, 1'b0);
    check({tag, "_exec_busy"}, busy, 1'b1);
    check({tag, "_exec_rdy"}, {req1_ready, req0_ready}, 2'b00);
  endtask

  task automatic cmp_rsp(input string tag, input rsp_t e);
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_id"}, rsp_id, e.id);
    check({tag, "_out"}, rsp_out, e.out);
    check({tag, "_z"}, rsp_z, e.z);
    check({tag, "_err"}, rsp_err, e.err);
    check({tag, "_rdy"}, {req1_ready, req0_ready}, 2'b00);
  endtask

  task automatic resp_check(input string tag, input int stall);
    rsp_t e;
    @(negedge clk);
    rsp_ready = (stall == 0);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      cmp_rsp(tag, e);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (i == stall - 1) rsp_ready = 1'b1;
        #1;
        cmp_rsp({tag, "_hold"}, e);
        check({tag, "_hold_busy"}, busy, 1'b1);
      end
    end
    rsp_ready = 1'b1;
  endtask

  task automatic op(input string tag,
                    input logic v0, input logic [3:0] c0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                    input logic v1, input logic [3:0] c1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                    input int stall);
    drive(v0, c0, a0, b0, v1, c1, a1, b1);
    grant_check(tag);
    exec_check(tag);
    resp_check(tag, stall);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_alu_ctl", alu_ctl, 4'b0000);
    check("rst_alu_a", alu_a, '0);
    check("rst_rsp_out", rsp_out, '0);
    check("rst_rsp_flags", {rsp_z, rsp_err, rsp_id}, 3'b000);
    check("rst_ready", {req1_ready, req0_ready}, 2'b00);
    sb.delete();
    tb_prio = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    op("add", 1'b1, ADD_C, 32'd15, 32'd126, 1'b0, AND_C, '0, '0, 0);

    // Pointer must restart at port 0 after reset even though it now points at 1.
    do_reset();
    op("rr0", 1'b1, SUB_C, 32'd15, 32'd15, 1'b1, OR_C, 32'hffff1010, 32'h0000ffff, 0);
    op("rr1", 1'b1, SUB_C, 32'd15, 32'd15, 1'b1, OR_C, 32'hffff1010, 32'h0000ffff, 0);
    op("rr2", 1'b1, SUB_C, 32'd15, 32'd15, 1'b1, OR_C, 32'hffff1010, 32'h0000ffff, 0);

    op("slt_lt", 1'b0, AND_C, '0, '0, 1'b1, SLT_C, 32'd10001, 32'd100000, 0);
    op("slt_ge", 1'b0, AND_C, '0, '0, 1'b1, SLT_C, 32'd100000, 32'd10001, 0);
    op("nor", 1'b1, NOR_C, 32'h0f0f_0000, 32'h0000_00ff, 1'b0, AND_C, '0, '0, 0);
    op("and", 1'b1, AND_C, 32'hf0f0_1234, 32'hff00_ff00, 1'b0, AND_C, '0, '0, 0);

    // Both requesters stay valid through a stalled response; the loser wins right after the handshake.
    op("stall", 1'b1, AND_C, 32'h0000_f0f0, 32'h0000_ff00, 1'b1, ADD_C, 32'd1, 32'd2, 5);
    op("after_stall", 1'b1, AND_C, 32'h0000_f0f0, 32'h0000_ff00, 1'b1, ADD_C, 32'd1, 32'd2, 0);

    op("illegal", 1'b1, 4'b1111, 32'd7, 32'd9, 1'b0, AND_C, '0, '0, 0);
    op("xor", 1'b0, AND_C, '0, '0, 1'b1, XOR_C, 32'd1010100, 32'd100000, 0);
    op("illegal3", 1'b1, 4'b0011, 32'd0, 32'd0, 1'b0, AND_C, '0, '0, 0);

    drive(1'b0, AND_C, '0, '0, 1'b0, AND_C, '0, '0);
    grant_check("idle");
    check("idle_busy0", busy, 1'b0);
    @(negedge clk);
    #1;
    check("idle_busy1", busy, 1'b0);
    check("idle_valid", rsp_valid, 1'b0);

    // Abort mid-EXEC after a port-0 grant has moved the pointer to port 1.
    drive(1'b1, ADD_C, 32'd5, 32'd6, 1'b0, AND_C, '0, '0);
    grant_check("abort");
    @(posedge clk);
    #2;
    reset = 1'b1;
    req0_valid = 1'b0;
    #1;
    check("abort_valid", rsp_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_alu_ctl", alu_ctl, 4'b0000);
    sb.delete();
    tb_prio = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("abort_no_rsp", rsp_valid, 1'b0);
    end
    op("post_abort", 1'b1, OR_C, 32'h1, 32'h2, 1'b1, ADD_C, 32'd3, 32'd4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench watchdog expired");
  end
endmodule
